// File: rtl/cache_pkg.sv
// cache_pkg: shared cache-hierarchy constants, responder state encoding, line-offset helper
package cache_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int LINE_WORDS = 4;
  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;
  function automatic int line_off_w(input int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port backing store, sync write, sync read with read enable
//   clk in, we in (write enable), re in (read enable), addr in [AW], wdata in [DW], rdata out [DW]
module mem_responder_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: main-memory responder serving L2 line fills and write-backs with fixed latency
//   clk, rst_n (async, active low)
//   req_valid/req_ready/req_write/req_addr : request channel (word address, any word of the line)
//   wdata_valid/wdata/wdata_ready          : write-back beats, LINE_WORDS per write request
//   rsp_valid/rsp_ready/rsp_data/rsp_last  : fill burst (ascending from line base) or single write ack
module mem_responder #(
  parameter int ADDR_W     = cache_pkg::ADDR_W,
  parameter int DATA_W     = cache_pkg::DATA_W,
  parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
  parameter int LATENCY    = 8,
  parameter int MEM_AW     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last
);
  import cache_pkg::*;
  localparam int OW = line_off_w(LINE_WORDS);
  localparam int LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  state_t state, state_nx;
  logic [LW-1:0] lat;
  logic [OW-1:0] beat;
  logic [MEM_AW-OW-1:0] line;
  logic op_wr;
  logic accept, wbeat, rbeat, beat_end;
  logic ram_re;
  logic [MEM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_W-1:MEM_AW], req_addr[OW-1:0]};
  assign req_ready   = state == IDLE;
  assign wdata_ready = state == WDATA;
  assign accept      = req_valid && req_ready;
  assign wbeat       = wdata_valid && wdata_ready;
  assign rbeat       = rsp_valid && rsp_ready;
  assign beat_end    = beat == OW'(LINE_WORDS - 1);
  assign rsp_last    = rsp_valid && (op_wr || beat_end);
  assign rsp_data    = (rsp_valid && !op_wr) ? ram_q : '0;
  // The RAM output register is the response data register: it is loaded once in the
  // first RESP cycle, then again only as a beat handshakes, so a stalled beat holds.
  assign ram_re   = state == RESP && !op_wr && (!rsp_valid || (rbeat && !rsp_last));
  assign ram_addr = {line, (state == RESP && rsp_valid) ? beat + OW'(1) : beat};
  mem_responder_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wbeat),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (ram_q)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = accept ? (req_write ? WDATA : WAIT) : IDLE;
      WDATA: state_nx = (wbeat && beat_end) ? WAIT : WDATA;
      WAIT:  state_nx = (lat == LW'(LATENCY)) ? RESP : WAIT;
      RESP:  state_nx = (rbeat && rsp_last) ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat       <= '0;
      beat      <= '0;
      line      <= '0;
      op_wr     <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        line  <= req_addr[MEM_AW-1:OW];
        op_wr <= req_write;
      end
      lat <= (state == WAIT && state_nx == WAIT) ? lat + LW'(1) : '0;
      if (wbeat || (rbeat && !op_wr)) beat <= beat + OW'(1);
      rsp_valid <= state == RESP && !(rbeat && rsp_last);
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized traffic against a word-array/queue model of the responder
module tb_mem_responder;
  localparam int LAT = 8;
  logic clk = 0;
  logic rst_n = 1;
  logic req_valid = 0, req_write = 0, wdata_valid = 0, rsp_ready = 1;
  logic [23:0] req_addr = '0;
  logic [31:0] wdata = '0;
  logic req_ready, wdata_ready, rsp_valid, rsp_last;
  logic [31:0] rsp_data;
  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wdata_valid(wdata_valid),
    .wdata(wdata), .wdata_ready(wdata_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last)
  );
  initial forever #5 clk = ~clk;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end
  typedef struct { logic [31:0] d; bit last; } beat_t;
  logic [31:0] mdl [1024];
  beat_t expq[$];
  int lines[$];
  bit busy = 0;
  int exp_rise = -1, rise_cyc = 0, acc_cyc = 0, hs_cnt = 0;
  int bp_mode = 0, stall_left = 0;
  logic [31:0] obs [4];
  int n_chk = 0, n_fail = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic send_req(input bit w, input logic [23:0] a);
    int n = 0;
    int idx;
    req_valid = 1; req_write = w; req_addr = a;
    while (!req_ready && n < 300) begin
      wdata_valid = 1'($urandom_range(0, 1)); wdata = $urandom;
      tick; n++;
    end
    if (n >= 300) chk("req_ready timeout", 0, 1);
    tick;
    req_valid = 0; req_write = 1'($urandom); req_addr = 24'($urandom); wdata_valid = 0;
    busy = 1; acc_cyc = cyc;
    idx = {a[9:2], 2'b00};
    if (!w) begin
      for (int i = 0; i < 4; i++) expq.push_back('{mdl[idx + i], i == 3});
      exp_rise = cyc + LAT + 2;
    end
  endtask
  task automatic do_write(input logic [23:0] a, input logic [31:0] d [4], input int nb, input bit gaps);
    int idx;
    idx = {a[9:2], 2'b00};
    send_req(1, a);
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin wdata = $urandom; tick; end
      wdata_valid = 1; wdata = d[i];
      tick;
      mdl[idx + i] = d[i];
      wdata_valid = 0;
    end
    if (nb == 4) begin
      expq.push_back('{32'h0, 1'b1});
      exp_rise = cyc + LAT + 2;
      lines.push_back(idx);
    end
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy && n < 500) begin
      wdata_valid = 1'($urandom_range(0, 1)); wdata = $urandom;
      tick; n++;
    end
    wdata_valid = 0;
    if (busy) chk("response timeout", 0, 1);
  endtask
  initial forever begin
    @(posedge clk); #2;
    if (bp_mode == 0) rsp_ready = 1;
    else if (bp_mode == 1) rsp_ready = $urandom_range(0, 3) != 0;
    else if (rsp_valid && hs_cnt == 1 && stall_left > 0) begin rsp_ready = 0; stall_left--; end
    else rsp_ready = 1;
  end
  bit prev_stall = 0, prev_v = 0, prev_l = 0;
  logic [31:0] prev_d = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 0; prev_v = 0;
    end else begin
      chk("req_ready", req_ready, !busy);
      if (!busy) begin
        chk("idle wdata_ready", wdata_ready, 0);
        chk("idle rsp_valid", rsp_valid, 0);
      end
      if (prev_stall) begin
        chk("hold valid", rsp_valid, 1);
        chk("hold data", rsp_data, prev_d);
        chk("hold last", rsp_last, prev_l);
      end
      if (rsp_valid && !prev_v) begin
        chk("first beat cycle", cyc, exp_rise);
        rise_cyc = cyc; exp_rise = -1;
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) chk("unexpected beat", 1, 0);
        else begin
          beat_t b;
          b = expq.pop_front();
          chk("rsp_data", rsp_data, b.d);
          chk("rsp_last", rsp_last, b.last);
          if (hs_cnt < 4) obs[hs_cnt] = rsp_data;
          hs_cnt++;
          if (b.last) begin busy = 0; hs_cnt = 0; end
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_v = rsp_valid; prev_d = rsp_data; prev_l = rsp_last;
    end
  end
  initial begin
    logic [31:0] d [4];
    #1 rst_n = 0;
    #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset wdata_ready", wdata_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_last", rsp_last, 0);
    tick; tick; rst_n = 1; tick;
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(24'h232320, d, 4, 0);
    wait_idle;
    chk("ack data literal", obs[0], 0);
    chk("req_ready after ack", req_ready, 1);
    send_req(0, 24'h232322);
    wait_idle;
    for (int i = 0; i < 4; i++) chk($sformatf("fill word %0d", i), obs[i], 32'hA0 + i);
    chk("fill latency", rise_cyc - acc_cyc, 10);
    bp_mode = 2; stall_left = 3;
    send_req(0, 24'h232321);
    wait_idle;
    for (int i = 0; i < 4; i++) chk($sformatf("bp word %0d", i), obs[i], 32'hA0 + i);
    chk("bp stall applied", stall_left, 0);
    bp_mode = 0;
    d = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(24'h000400, d, 4, 1);
    wait_idle;
    send_req(0, 24'h000000);
    wait_idle;
    for (int i = 0; i < 4; i++) chk($sformatf("alias word %0d", i), obs[i], i + 1);
    d = '{32'h11, 32'h12, 32'h13, 32'h14};
    do_write(24'h000010, d, 4, 0);
    wait_idle;
    d = '{32'h21, 32'h22, 32'h23, 32'h24};
    do_write(24'h000010, d, 2, 0);
    rst_n = 0;
    #1;
    chk("abort req_ready", req_ready, 1);
    chk("abort wdata_ready", wdata_ready, 0);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort rsp_data", rsp_data, 0);
    chk("abort rsp_last", rsp_last, 0);
    busy = 0; expq.delete(); exp_rise = -1; hs_cnt = 0;
    tick; tick; rst_n = 1; tick;
    send_req(0, 24'h000013);
    wait_idle;
    chk("abort word 0", obs[0], 32'h21);
    chk("abort word 1", obs[1], 32'h22);
    chk("abort word 2", obs[2], 32'h13);
    chk("abort word 3", obs[3], 32'h14);
    bp_mode = 1;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        do_write(24'($urandom), d, 4, 1);
      end else begin
        int idx;
        idx = lines[$urandom_range(0, lines.size() - 1)];
        send_req(0, {14'($urandom), idx[9:2], 2'($urandom)});
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick;
    end
    wait_idle;
    bp_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
